// File: rtl/ours_xm_to_jtag_xfer_sched_pkg.sv
// Shared constants and FSM encoding for the XM-to-JTAG transfer scheduler.
package ours_xm_to_jtag_pkg;

    localparam int XM2J_DATA_W = 128;
    localparam int XM2J_RSP_W  = 64;
    localparam int XM2J_SIZE_W = 8;

    // 3-bit scheduler state, kept as plain constants for legacy tooling
    typedef logic [2:0] xm2j_state_t;
    localparam xm2j_state_t ST_IDLE  = 3'd0;
    localparam xm2j_state_t ST_ISSUE = 3'd1;
    localparam xm2j_state_t ST_WAIT  = 3'd2;
    localparam xm2j_state_t ST_RESP  = 3'd3;
    localparam xm2j_state_t ST_LOCK  = 3'd4;

    // A shift length is usable by the engine only when 1..128 bits
    function automatic logic size_ok(input logic [XM2J_SIZE_W-1:0] s);
        return (s != '0) && (s <= 8'd128);
    endfunction

endpackage

// File: rtl/ours_xm_to_jtag_xfer_sched_if.sv
// Requester, response and engine signals of the scheduler grouped in one bundle.
// slave = scheduler side, master = requesters/engine side.
interface ours_xm_to_jtag_xfer_sched_if #(
    parameter int N_REQ     = 2,
    parameter int CODE_SIZE = 4
);
    import ours_xm_to_jtag_pkg::*;

    logic [N_REQ-1:0]             req_vld_i;
    logic [N_REQ-1:0]             req_rdy_o;
    logic [N_REQ*CODE_SIZE-1:0]   req_inst_i;
    logic [N_REQ*XM2J_DATA_W-1:0] req_data_i;
    logic [N_REQ*XM2J_SIZE_W-1:0] req_size_i;
    logic [N_REQ-1:0]             rsp_vld_o;
    logic [XM2J_RSP_W-1:0]        rsp_data_o;
    logic                         rsp_err_o;
    logic                         eng_vld_o;
    logic [CODE_SIZE-1:0]         eng_inst_o;
    logic [XM2J_DATA_W-1:0]       eng_data_o;
    logic [XM2J_SIZE_W-1:0]       eng_size_o;
    logic                         eng_done_i;
    logic [XM2J_RSP_W-1:0]        eng_data_i;
    logic                         err_timeout_o;
    logic                         clr_i;

    modport slave (
        input  req_vld_i, req_inst_i, req_data_i, req_size_i,
        input  eng_done_i, eng_data_i, clr_i,
        output req_rdy_o, rsp_vld_o, rsp_data_o, rsp_err_o,
        output eng_vld_o, eng_inst_o, eng_data_o, eng_size_o, err_timeout_o
    );

    modport master (
        output req_vld_i, req_inst_i, req_data_i, req_size_i,
        output eng_done_i, eng_data_i, clr_i,
        input  req_rdy_o, rsp_vld_o, rsp_data_o, rsp_err_o,
        input  eng_vld_o, eng_inst_o, eng_data_o, eng_size_o, err_timeout_o
    );

endinterface

// File: rtl/ours_xm_to_jtag_xfer_sched_rr_arb.sv
// Combinational rotate-priority arbiter: search starts one past ptr_i and wraps.
module ours_xm_to_jtag_rr_arb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int off);
        int k;
        k = int'(p) + off;
        if (k >= N_REQ) k = k - N_REQ;
        return IDX_W'(k);
    endfunction

    // First requester found after the pointer wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!any_o && req_i[wrap_idx(ptr_i, i)]) begin
                any_o                      = 1'b1;
                idx_o                      = wrap_idx(ptr_i, i);
                gnt_o[wrap_idx(ptr_i, i)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ours_xm_to_jtag_xfer_sched.sv
// Schedules N requesters onto a single JTAG shift engine, one command per grant,
// and routes the captured TDO word back to the granted requester.
// Optional WAIT watchdog and LOCK state: define OURS_XM_TO_JTAG_SCHED_TIMEOUT_EN.
module ours_xm_to_jtag_xfer_sched
    import ours_xm_to_jtag_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int CODE_SIZE   = 4,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic                         clk,
    input  logic                         rst_n,
    ours_xm_to_jtag_xfer_sched_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [CODE_SIZE-1:0]   inst_arr [N_REQ];
    logic [XM2J_DATA_W-1:0] data_arr [N_REQ];
    logic [XM2J_SIZE_W-1:0] size_arr [N_REQ];

    // Unpack the flat requester buses into per-requester slices
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign inst_arr[gi] = bus.req_inst_i[gi*CODE_SIZE +: CODE_SIZE];
            assign data_arr[gi] = bus.req_data_i[gi*XM2J_DATA_W +: XM2J_DATA_W];
            assign size_arr[gi] = bus.req_size_i[gi*XM2J_SIZE_W +: XM2J_SIZE_W];
        end
    endgenerate

    xm2j_state_t            state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, gidx_q;
    logic [CODE_SIZE-1:0]   inst_q;
    logic [XM2J_DATA_W-1:0] data_q;
    logic [XM2J_SIZE_W-1:0] size_q;
    logic                   err_q;
    logic [XM2J_RSP_W-1:0]  cap_q;

    logic [N_REQ-1:0]       gnt;
    logic [IDX_W-1:0]       gidx;
    logic                   gany;
    logic                   accept;
    logic                   timeout_hit;

    ours_xm_to_jtag_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req_i (bus.req_vld_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    assign accept = (state_q == ST_IDLE) && gany;

`ifdef OURS_XM_TO_JTAG_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q;
    logic        err_to_q;
    logic        lock_pend_q;

    assign timeout_hit = (state_q == ST_WAIT) && !bus.eng_done_i && (cnt_q == TO_LAST);
    assign bus.err_timeout_o = err_to_q;

    // WAIT watchdog, sticky timeout flag and the pending LOCK after the error response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            err_to_q    <= 1'b0;
            lock_pend_q <= 1'b0;
        end else begin
            if (state_q == ST_WAIT) cnt_q <= cnt_q + 16'd1;
            else                    cnt_q <= '0;
            if (bus.clr_i) err_to_q <= 1'b0;
            if (timeout_hit) begin
                err_to_q    <= 1'b1;
                lock_pend_q <= 1'b1;
            end else if (state_q == ST_RESP) begin
                lock_pend_q <= 1'b0;
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr        = bus.clr_i;
    assign timeout_hit       = 1'b0;
    assign bus.err_timeout_o = 1'b0;
`endif

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (gany) state_d = size_ok(size_arr[gidx]) ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.eng_done_i || timeout_hit) state_d = ST_RESP;
`ifdef OURS_XM_TO_JTAG_SCHED_TIMEOUT_EN
            ST_RESP:  state_d = lock_pend_q ? ST_LOCK : ST_IDLE;
            ST_LOCK:  if (bus.eng_done_i || bus.clr_i) state_d = ST_IDLE;
`else
            ST_RESP:  state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, grant pointer, latched command and captured response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            gidx_q  <= '0;
            inst_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q  <= gidx;
                gidx_q <= gidx;
                inst_q <= inst_arr[gidx];
                data_q <= data_arr[gidx];
                size_q <= size_arr[gidx];
                err_q  <= !size_ok(size_arr[gidx]);
                cap_q  <= '0;
            end else if (state_q == ST_WAIT && bus.eng_done_i) begin
                cap_q  <= bus.eng_data_i;
            end else if (timeout_hit) begin
                cap_q  <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    assign bus.req_rdy_o  = accept ? gnt : '0;
    assign bus.eng_vld_o  = (state_q == ST_ISSUE);
    assign bus.eng_inst_o = inst_q;
    assign bus.eng_data_o = data_q;
    assign bus.eng_size_o = size_q;
    assign bus.rsp_vld_o  = (state_q == ST_RESP) ? (N_REQ'(1) << gidx_q) : '0;
    assign bus.rsp_data_o = (state_q == ST_RESP) ? cap_q : '0;
    assign bus.rsp_err_o  = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_ours_xm_to_jtag_xfer_sched.sv
// Randomized bench for the XM-to-JTAG scheduler with a transaction-level reference model.
module tb_ours_xm_to_jtag_xfer_sched;

    localparam int N  = 3;
    localparam int CS = 4;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ours_xm_to_jtag_xfer_sched_if #(.N_REQ(N), .CODE_SIZE(CS)) bus ();

    ours_xm_to_jtag_xfer_sched #(.N_REQ(N), .CODE_SIZE(CS), .TIMEOUT_CYC(TO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model: pending requests per requester and the round-robin pointer
    bit          pend   [N];
    logic [CS-1:0] m_inst [N];
    logic [127:0]  m_data [N];
    logic [7:0]    m_size [N];
    int          m_ptr;
    int          n_chk = 0;
    int          n_bad = 0;
    int          n_txn = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bus();
        for (int k = 0; k < N; k++) begin
            bus.req_vld_i[k]               = pend[k];
            bus.req_inst_i[k*CS +: CS]     = m_inst[k];
            bus.req_data_i[k*128 +: 128]   = m_data[k];
            bus.req_size_i[k*8 +: 8]       = m_size[k];
        end
    endtask

    task automatic new_req(input int k, input logic [7:0] sz);
        pend[k]   = 1'b1;
        m_inst[k] = CS'($urandom);
        m_data[k] = {$urandom, $urandom, $urandom, $urandom};
        m_size[k] = sz;
    endtask

    function automatic logic [7:0] rand_size();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'($urandom_range(129, 255));
        return 8'($urandom_range(1, 128));
    endfunction

    // Grant rule: first pending requester after the last grant, wrapping
    function automatic int exp_grant();
        for (int i = 1; i <= N; i++) begin
            if (pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_rsp_vld"}, bus.rsp_vld_o, 0);
        check_val({tag, "_rsp_data"}, bus.rsp_data_o, 0);
        check_val({tag, "_rsp_err"}, bus.rsp_err_o, 0);
        check_val({tag, "_eng_vld"}, bus.eng_vld_o, 0);
    endtask

    // One full transaction starting at a negedge in IDLE with something pending
    task automatic do_txn(input int delay, input bit stray);
        int g;
        bit legal;
        logic [CS-1:0] inst;
        logic [127:0]  data;
        logic [7:0]    sz;
        logic [63:0]   d;
        drive_bus();
        #1;
        g = exp_grant();
        check_val("rdy", bus.req_rdy_o, 128'(1) << g);
        inst  = m_inst[g];
        data  = m_data[g];
        sz    = m_size[g];
        legal = (sz != 0) && (sz <= 8'd128);
        d     = 64'h0;
        @(negedge clk);
        pend[g] = 1'b0;
        m_ptr   = g;
        drive_bus();
        if (legal) begin
            check_val("eng_vld", bus.eng_vld_o, 1);
            check_val("eng_size", bus.eng_size_o, sz);
            check_val("eng_inst", bus.eng_inst_o, inst);
            check_val("eng_data", bus.eng_data_o, data);
            check_val("issue_rsp", bus.rsp_vld_o, 0);
            check_val("issue_rdy", bus.req_rdy_o, 0);
            if (stray) begin
                bus.eng_done_i = 1'b1;
                bus.eng_data_i = {$urandom, $urandom};
            end
            @(negedge clk);
            bus.eng_done_i = 1'b0;
            check_val("wait_rsp", bus.rsp_vld_o, 0);
            for (int c = 0; c < delay; c++) begin
                check_val("wait_eng_vld", bus.eng_vld_o, 0);
                check_val("wait_size", bus.eng_size_o, sz);
                @(negedge clk);
            end
            d = {$urandom, $urandom};
            bus.eng_done_i = 1'b1;
            bus.eng_data_i = d;
            @(negedge clk);
            bus.eng_done_i = 1'b0;
            bus.eng_data_i = 64'h0;
            check_val("rsp_vld", bus.rsp_vld_o, 128'(1) << g);
            check_val("rsp_data", bus.rsp_data_o, d);
            check_val("rsp_err", bus.rsp_err_o, 0);
        end else begin
            check_val("bad_eng_vld", bus.eng_vld_o, 0);
            check_val("bad_rsp_vld", bus.rsp_vld_o, 128'(1) << g);
            check_val("bad_rsp_err", bus.rsp_err_o, 1);
            check_val("bad_rsp_data", bus.rsp_data_o, 0);
        end
        $display("txn %0d: req=%0d size=%0d delay=%0d stray=%0d rsp=%0h", n_txn, g, sz, delay, stray, d);
        n_txn++;
        @(negedge clk);
        check_idle_outputs("post");
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0; m_inst[k] = '0; m_data[k] = '0; m_size[k] = '0;
        end
        m_ptr = N - 1;
        bus.eng_done_i = 1'b0;
        bus.eng_data_i = 64'h0;
        bus.clr_i      = 1'b0;
        drive_bus();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_val("reset_rdy", bus.req_rdy_o, 0);
        check_val("reset_eng_size", bus.eng_size_o, 0);
        check_val("reset_eng_data", bus.eng_data_o, 0);
        check_val("reset_to", bus.err_timeout_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester, size 32, done 47 cycles after the engine strobe
        new_req(0, 8'd32);
        m_data[0] = 128'hA5A5_0001;
        do_txn(46, 1'b0);

        // Two requesters held continuously: alternate grants
        for (int i = 0; i < 4; i++) begin
            if (!pend[0]) new_req(0, 8'($urandom_range(1, 128)));
            if (!pend[1]) new_req(1, 8'($urandom_range(1, 128)));
            do_txn($urandom_range(0, 5), 1'b0);
        end
        pend[0] = 1'b0; pend[1] = 1'b0;

        // Illegal sizes never reach the engine
        new_req(2, 8'd0);
        do_txn(0, 1'b0);
        new_req(2, 8'd200);
        do_txn(0, 1'b0);

        // Stray done while idle produces nothing
        drive_bus();
        bus.eng_done_i = 1'b1;
        bus.eng_data_i = 64'hDEAD;
        @(negedge clk);
        bus.eng_done_i = 1'b0;
        check_idle_outputs("idle_done");

        // Reset during WAIT, stale done afterwards, then a clean accept
        new_req(0, 8'd64);
        drive_bus();
        #1;
        check_val("rst5_rdy", bus.req_rdy_o, 128'(1) << exp_grant());
        @(negedge clk);
        pend[0] = 1'b0;
        drive_bus();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst5");
        check_val("rst5_size", bus.eng_size_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = N - 1;
        bus.eng_done_i = 1'b1;
        bus.eng_data_i = 64'hBEEF;
        @(negedge clk);
        bus.eng_done_i = 1'b0;
        check_idle_outputs("stale_done");
        new_req(1, 8'd12);
        do_txn(2, 1'b0);

`ifdef OURS_XM_TO_JTAG_SCHED_TIMEOUT_EN
        begin
            int c;
            new_req(0, 8'd16);
            drive_bus();
            #1;
            check_val("to_rdy", bus.req_rdy_o, 128'(1) << exp_grant());
            @(negedge clk);
            pend[0] = 1'b0;
            m_ptr   = 0;
            drive_bus();
            check_val("to_eng_vld", bus.eng_vld_o, 1);
            c = 0;
            while (bus.rsp_vld_o == 0 && c < 100) begin
                @(negedge clk);
                c++;
            end
            check_val("to_latency", c, TO + 1);
            check_val("to_rsp_err", bus.rsp_err_o, 1);
            check_val("to_rsp_data", bus.rsp_data_o, 0);
            check_val("to_flag", bus.err_timeout_o, 1);
            new_req(1, 8'd8);
            drive_bus();
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check_val("lock_rdy", bus.req_rdy_o, 0);
            end
            bus.clr_i = 1'b1;
            @(negedge clk);
            bus.clr_i = 1'b0;
            check_val("clr_flag", bus.err_timeout_o, 0);
            do_txn(3, 1'b0);
        end
`endif

        // Randomized contention
        for (int i = 0; i < 40; i++) begin
            bit any;
            any = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) new_req(k, rand_size());
                any = any | pend[k];
            end
            if (!any) new_req($urandom_range(0, N - 1), rand_size());
            do_txn($urandom_range(0, 12), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
